// File: rtl/dest_scoreboard_pkg.sv
// Shared opcode constants, tracked-entry record and mask helper for the
// destination scoreboard.
package dest_scoreboard_pkg;

  localparam int RA_W = 3;
  localparam int NREG = 1 << RA_W;

  localparam logic [3:0] OP_ADI  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LWI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_JAL  = 4'b1001;
  localparam logic [3:0] OP_JLR  = 4'b1010;
  localparam logic [3:0] OP_LM   = 4'b1100;
  localparam logic [3:0] OP_LA   = 4'b1110;

  // One tracked pipeline slot. The mask is only meaningful while the
  // entry is an LM/LA sitting in EX; elsewhere it stays zero.
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dest;
    logic            is_load;
    logic            is_multi;
    logic [NREG-1:0] mask;
  } entry_t;

  // Index of the lowest set bit; zero when the mask is empty.
  function automatic logic [RA_W-1:0] lowest_set(input logic [NREG-1:0] m);
    lowest_set = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = RA_W'(i);
    end
  endfunction

endpackage

// File: rtl/dest_decode.sv
// Combinational instruction -> tracked-entry decoder.
module dest_decode
  import dest_scoreboard_pkg::*;
(
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output entry_t      entry
);

  // Map opcode to destination, load and multi-register attributes.
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    entry = '0;
    if (instr_valid) begin
      case (instr[15:12])
        OP_ADD, OP_NAND: begin
          entry.valid = 1'b1;
          entry.dest  = instr[5:3];
        end
        OP_ADI: begin
          entry.valid = 1'b1;
          entry.dest  = instr[8:6];
        end
        OP_LWI, OP_LW: begin
          entry.valid   = 1'b1;
          entry.dest    = instr[11:9];
          entry.is_load = 1'b1;
        end
        OP_JAL, OP_JLR: begin
          entry.valid = 1'b1;
          entry.dest  = instr[11:9];
        end
        // Multi-register loads carry no single destination; their
        // registers are pushed one at a time from the mask.
        OP_LM: begin
          entry.is_load  = 1'b1;
          entry.is_multi = 1'b1;
          entry.mask     = instr[NREG-1:0];
        end
        OP_LA: begin
          entry.is_load  = 1'b1;
          entry.is_multi = 1'b1;
          entry.mask     = '1;
        end
        default: entry = '0;
      endcase
    end
  end

endmodule

// File: rtl/dest_scoreboard.sv
// Pipelined destination tracker for EX/MEM/WB with LM/LA sequencing and
// two-operand hazard queries.
module dest_scoreboard
  import dest_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int SIDX_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       id_instr,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [RA_W-1:0]   rs1_addr,
  input  logic [RA_W-1:0]   rs2_addr,
  output logic              seq_busy,
  output logic              hit_rs1,
  output logic              hit_rs2,
  output logic [SIDX_W-1:0] sel_rs1,
  output logic [SIDX_W-1:0] sel_rs2,
  output logic              load_use,
  output logic [RA_W-1:0]   wb_dest,
  output logic              wb_valid
);

  entry_t stage_q [STAGES];
  entry_t id_entry;
  entry_t push_entry;

  logic            multi_active;
  logic [NREG-1:0] mask_rest;

  dest_decode u_decode (
    .instr       (id_instr),
    .instr_valid (id_valid),
    .entry       (id_entry)
  );

  // The mask with its lowest set bit removed; more than one bit remains
  // pending exactly when this is non-zero.
  assign multi_active = stage_q[0].is_multi;
  assign mask_rest    = stage_q[0].mask & (stage_q[0].mask - NREG'(1));
  assign seq_busy     = multi_active && (mask_rest != '0);

  // Select what enters MEM: the next sequenced register or the EX entry.
  always_comb begin
    push_entry = stage_q[0];
    if (multi_active) begin
      push_entry         = '0;
      push_entry.valid   = (stage_q[0].mask != '0);
      push_entry.dest    = lowest_set(stage_q[0].mask);
      push_entry.is_load = push_entry.valid;
    end
  end

  // Stage registers: reset, flush squash, stall hold, then advance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its neighbour.
    if (reset) begin
      // NOTE: these few slots are control state, not storage, so each is
      // cleared; a stale valid bit would raise false hazards.
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (flush) begin
      stage_q[0] <= '0;
      if (!stall) begin
        stage_q[1] <= '0;
        for (int i = 2; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
    end else if (!stall) begin
      stage_q[1] <= push_entry;
      for (int i = 2; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      if (seq_busy) stage_q[0].mask <= mask_rest;
      else          stage_q[0]      <= id_entry;
    end
  end

  logic [1:0][RA_W-1:0]   rs_addr;
  logic [1:0]             hit;
  logic [1:0]             pend;
  logic [1:0][SIDX_W-1:0] sel;

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;

  // Hazard lookup per operand; scanning oldest-to-youngest leaves the
  // youngest match in sel, and a pending LM/LA register always wins.
  always_comb begin
    hit  = '0;
    pend = '0;
    sel  = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (stage_q[i].valid && (stage_q[i].dest == rs_addr[r])) begin
          hit[r] = 1'b1;
          sel[r] = SIDX_W'(i);
        end
      end
      if (multi_active && stage_q[0].mask[rs_addr[r]]) begin
        pend[r] = 1'b1;
        hit[r]  = 1'b1;
        sel[r]  = '0;
      end
    end
  end

  assign hit_rs1  = hit[0];
  assign hit_rs2  = hit[1];
  assign sel_rs1  = sel[0];
  assign sel_rs2  = sel[1];
  assign load_use = (stage_q[0].valid && stage_q[0].is_load &&
                     ((stage_q[0].dest == rs1_addr) || (stage_q[0].dest == rs2_addr)))
                    || (pend != '0);
  assign wb_dest  = stage_q[STAGES-1].dest;
  assign wb_valid = stage_q[STAGES-1].valid;

endmodule

// File: tb/tb_dest_scoreboard.sv
// Directed bench for dest_scoreboard: each task drives a scenario and
// compares the packed output bundle against hand-derived values.
module tb_dest_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        stall;
  logic        flush;
  logic [2:0]  rs1_addr;
  logic [2:0]  rs2_addr;
  logic        seq_busy;
  logic        hit_rs1;
  logic        hit_rs2;
  logic [1:0]  sel_rs1;
  logic [1:0]  sel_rs2;
  logic        load_use;
  logic [2:0]  wb_dest;
  logic        wb_valid;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [15:0] I_ADD_R1 = 16'b0001_101_110_001_001;
  localparam logic [15:0] I_LW_R5  = 16'b0100_101_110_001001;
  localparam logic [15:0] I_LM_25  = 16'hC025;
  localparam logic [15:0] I_LM_0   = 16'hC000;
  localparam logic [15:0] I_LA     = 16'hE000;
  localparam logic [15:0] I_ADD_R3 = 16'h1018;
  localparam logic [15:0] I_ADI_R3 = 16'h00C0;
  localparam logic [15:0] I_JAL_R6 = 16'h9C00;
  localparam logic [15:0] I_BAD    = 16'h5E00;
  localparam logic [15:0] I_LWI_R3 = 16'h3600;

  always #5 clk = ~clk;

  dest_scoreboard #(.STAGES(3), .SIDX_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .id_instr (id_instr),
    .id_valid (id_valid),
    .stall    (stall),
    .flush    (flush),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .seq_busy (seq_busy),
    .hit_rs1  (hit_rs1),
    .hit_rs2  (hit_rs2),
    .sel_rs1  (sel_rs1),
    .sel_rs2  (sel_rs2),
    .load_use (load_use),
    .wb_dest  (wb_dest),
    .wb_valid (wb_valid)
  );

  // {busy, hit1, sel1, hit2, sel2, load_use, wb_valid, wb_dest}
  logic [11:0] obs;
  assign obs = {seq_busy, hit_rs1, sel_rs1, hit_rs2, sel_rs2, load_use, wb_valid, wb_dest};

  function automatic logic [11:0] pk(input logic busy, input logic h1, input logic [1:0] s1,
                                     input logic h2, input logic [1:0] s2, input logic lu,
                                     input logic wv, input logic [2:0] wd);
    pk = {busy, h1, s1, h2, s2, lu, wv, wd};
  endfunction

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    id_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    reset = 1'b1; id_instr = I_ADD_R1; id_valid = 1'b1;
    stall = 1'b0; flush = 1'b0; rs1_addr = 3'd0; rs2_addr = 3'd0;
    tick();
    exp = pk(0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== exp) begin miscompares++; $display("FAIL reset_state: got %b want %b", obs, exp); end
    vectors++;
    reset = 1'b0; id_valid = 1'b0;
    tick();
    if (obs !== exp) begin miscompares++; $display("FAIL reset_idle: got %b want %b", obs, exp); end
    vectors++;
  endtask

  task automatic test_add();
    logic [11:0] exp [4];
    exp[0] = pk(0, 1, 0, 0, 0, 0, 0, 3'd0);
    exp[1] = pk(0, 1, 1, 0, 0, 0, 0, 3'd0);
    exp[2] = pk(0, 1, 2, 0, 0, 0, 1, 3'd1);
    exp[3] = pk(0, 0, 0, 0, 0, 0, 0, 3'd0);
    id_instr = I_ADD_R1; id_valid = 1'b1; rs1_addr = 3'd1; rs2_addr = 3'd0;
    for (int e = 0; e < 4; e++) begin
      tick();
      id_valid = 1'b0;  // opcode stays ADD, so this also checks bubble gating
      if (obs !== exp[e]) begin
        miscompares++; $display("FAIL add_edge%0d: got %b want %b", e + 1, obs, exp[e]);
      end
      vectors++;
    end
  endtask

  task automatic test_load_use();
    logic [11:0] exp [4];
    exp[0] = pk(0, 0, 0, 1, 0, 1, 0, 3'd0);
    exp[1] = pk(0, 0, 0, 1, 1, 0, 0, 3'd0);
    exp[2] = pk(0, 0, 0, 1, 2, 0, 1, 3'd5);
    exp[3] = pk(0, 0, 0, 0, 0, 0, 0, 3'd0);
    id_instr = I_LW_R5; id_valid = 1'b1; rs1_addr = 3'd0; rs2_addr = 3'd5;
    for (int e = 0; e < 4; e++) begin
      tick();
      id_valid = 1'b0;
      if (obs !== exp[e]) begin
        miscompares++; $display("FAIL lw_edge%0d: got %b want %b", e + 1, obs, exp[e]);
      end
      vectors++;
    end
  endtask

  task automatic test_lm();
    logic [11:0] exp [6];
    logic [2:0]  q1 [6];
    logic [2:0]  q2 [6];
    q1 = '{3'd5, 3'd0, 3'd2, 3'd5, 3'd5, 3'd5};
    q2 = '{3'd0, 3'd2, 3'd5, 3'd1, 3'd1, 3'd1};
    exp[0] = pk(1, 1, 0, 1, 0, 1, 0, 3'd0);
    exp[1] = pk(1, 1, 1, 1, 0, 1, 0, 3'd0);
    exp[2] = pk(0, 1, 1, 1, 0, 1, 1, 3'd0);
    exp[3] = pk(0, 1, 1, 1, 0, 0, 1, 3'd2);
    exp[4] = pk(0, 1, 2, 1, 1, 0, 1, 3'd5);
    exp[5] = pk(0, 0, 0, 1, 2, 0, 1, 3'd1);
    id_instr = I_LM_25; id_valid = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      // Decode holds the ADD behind the LM until it is accepted at edge 4.
      id_instr = I_ADD_R1;
      id_valid = (e < 3);
      rs1_addr = q1[e]; rs2_addr = q2[e];
      #1;
      if (obs !== exp[e]) begin
        miscompares++; $display("FAIL lm_edge%0d: got %b want %b", e + 1, obs, exp[e]);
      end
      vectors++;
    end
  endtask

  task automatic test_la();
    id_instr = I_LA; id_valid = 1'b1; rs1_addr = 3'd0; rs2_addr = 3'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      id_valid = 1'b0;
      if (seq_busy !== (i < 7)) begin
        miscompares++; $display("FAIL la_busy%0d: got %b want %b", i, seq_busy, (i < 7));
      end
      vectors++;
      if (i >= 2) begin
        if ({wb_valid, wb_dest} !== {1'b1, 3'(i - 2)}) begin
          miscompares++; $display("FAIL la_wb%0d: got %b_%0d want 1_%0d", i, wb_valid, wb_dest, i - 2);
        end
      end else if (wb_valid !== 1'b0) begin
        miscompares++; $display("FAIL la_wb%0d: got valid %b want 0", i, wb_valid);
      end
      vectors++;
    end
    for (int k = 6; k < 9; k++) begin
      tick();
      if ({wb_valid, wb_dest} !== ((k < 8) ? {1'b1, 3'(k)} : 4'b0000)) begin
        miscompares++; $display("FAIL la_tail%0d: got %b_%0d", k, wb_valid, wb_dest);
      end
      vectors++;
    end
  endtask

  task automatic test_lm_zero();
    logic [11:0] exp [4];
    exp[0] = pk(0, 0, 0, 0, 0, 0, 0, 3'd0);
    exp[1] = pk(0, 0, 0, 1, 0, 0, 0, 3'd0);
    exp[2] = pk(0, 0, 0, 1, 1, 0, 0, 3'd0);
    exp[3] = pk(0, 0, 0, 1, 2, 0, 1, 3'd1);
    id_instr = I_LM_0; id_valid = 1'b1; rs1_addr = 3'd0; rs2_addr = 3'd1;
    for (int e = 0; e < 4; e++) begin
      tick();
      id_instr = I_ADD_R1;
      id_valid = (e == 0);
      #1;
      if (obs !== exp[e]) begin
        miscompares++; $display("FAIL lm0_edge%0d: got %b want %b", e + 1, obs, exp[e]);
      end
      vectors++;
    end
  endtask

  task automatic test_youngest_stall();
    logic [11:0] exp;
    id_instr = I_ADD_R1; id_valid = 1'b1;
    tick(); id_instr = I_ADD_R3;
    tick(); id_instr = I_ADI_R3;
    tick();
    // WB=ADD r1, MEM=ADD r3, EX=ADI r3; LW offered under stall must be ignored.
    id_instr = I_LW_R5; stall = 1'b1; rs1_addr = 3'd3; rs2_addr = 3'd1;
    #1;
    exp = pk(0, 1, 0, 1, 2, 0, 1, 3'd1);
    if (obs !== exp) begin miscompares++; $display("FAIL youngest: got %b want %b", obs, exp); end
    vectors++;
    for (int s = 0; s < 2; s++) begin
      tick();
      if (obs !== exp) begin
        miscompares++; $display("FAIL stall%0d: got %b want %b", s, obs, exp);
      end
      vectors++;
    end
    stall = 1'b0; id_valid = 1'b0;
    tick();
    rs2_addr = 3'd5;
    #1;
    exp = pk(0, 1, 1, 0, 0, 0, 1, 3'd3);
    if (obs !== exp) begin miscompares++; $display("FAIL post_stall: got %b want %b", obs, exp); end
    vectors++;
  endtask

  task automatic test_flush();
    logic [11:0] exp [5];
    exp[0] = pk(1, 1, 0, 1, 0, 1, 0, 3'd0);
    exp[1] = pk(1, 1, 0, 1, 0, 1, 0, 3'd0);
    exp[2] = pk(0, 0, 0, 0, 0, 0, 1, 3'd0);
    exp[3] = pk(0, 0, 0, 0, 0, 0, 0, 3'd0);
    exp[4] = pk(0, 0, 0, 0, 0, 0, 0, 3'd0);
    id_instr = I_LM_25; id_valid = 1'b1; rs1_addr = 3'd2; rs2_addr = 3'd5;
    for (int e = 0; e < 5; e++) begin
      tick();
      id_valid = 1'b0;
      flush    = (e == 1);
      #1;
      if (obs !== exp[e]) begin
        miscompares++; $display("FAIL flush_edge%0d: got %b want %b", e + 1, obs, exp[e]);
      end
      vectors++;
    end
  endtask

  task automatic test_reset_mid_la();
    logic [11:0] exp;
    id_instr = I_LA; id_valid = 1'b1; rs1_addr = 3'd7; rs2_addr = 3'd6;
    tick(); id_valid = 1'b0;
    tick(); tick();
    if (seq_busy !== 1'b1) begin miscompares++; $display("FAIL la_pre_reset: got %b want 1", seq_busy); end
    vectors++;
    reset = 1'b1;
    tick();
    exp = pk(0, 0, 0, 0, 0, 0, 0, 3'd0);
    if (obs !== exp) begin miscompares++; $display("FAIL reset_mid_la: got %b want %b", obs, exp); end
    vectors++;
    reset = 1'b0;
    tick();
    if (obs !== exp) begin miscompares++; $display("FAIL after_reset_la: got %b want %b", obs, exp); end
    vectors++;
  endtask

  task automatic test_decode_misc();
    logic [11:0] exp;
    id_instr = I_JAL_R6; id_valid = 1'b1; rs1_addr = 3'd6; rs2_addr = 3'd0;
    tick();
    id_instr = I_BAD; rs1_addr = 3'd7; rs2_addr = 3'd6;
    #1;
    exp = pk(0, 0, 0, 1, 0, 0, 0, 3'd0);
    if (obs !== exp) begin miscompares++; $display("FAIL jal_ex: got %b want %b", obs, exp); end
    vectors++;
    tick();
    id_instr = I_LWI_R3;
    #1;
    exp = pk(0, 0, 0, 1, 1, 0, 0, 3'd0);
    if (obs !== exp) begin miscompares++; $display("FAIL bad_opcode: got %b want %b", obs, exp); end
    vectors++;
    tick();
    id_valid = 1'b0; rs1_addr = 3'd3;
    #1;
    exp = pk(0, 1, 0, 1, 2, 1, 1, 3'd6);
    if (obs !== exp) begin miscompares++; $display("FAIL lwi_ex: got %b want %b", obs, exp); end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_add();            drain();
    test_load_use();       drain();
    test_lm();             drain();
    test_la();             drain();
    test_lm_zero();        drain();
    test_youngest_stall(); drain();
    test_flush();          drain();
    test_reset_mid_la();   drain();
    test_decode_misc();    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dest_scoreboard.md
Name: dest_scoreboard

Overview:
- Pipelined destination-register tracker for the 5-stage core. It replaces the per-stage combinational destination decoders with one sequential block.
- Decodes the destination and valid bit of each instruction leaving decode, then carries them through EX/MEM/WB.
- Sequences LM/LA multi-register writes internally, with its own k counter.
- Answers hazard queries for two source operands with a match flag, a youngest-match stage index and a load-use stall.

Parameters:
- RA_W, 3, register address width.
- NREG, 8, number of architectural registers (2**RA_W).
- STAGES, 3, tracked stages after decode: index 0=EX, 1=MEM, 2=WB; must be >=2.
- SIDX_W, 2, width of stage index outputs (clog2(STAGES)).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- id_instr  in  16  instruction leaving decode.
- id_valid  in  1  id_instr is a real instruction (0 = bubble).
- stall  in  1  freeze every tracked stage.
- flush  in  1  squash the EX entry and any LM/LA sequence in progress.
- rs1_addr  in  RA_W  source operand 1 to query.
- rs2_addr  in  RA_W  source operand 2 to query.
- seq_busy  out  1  LM/LA sequence active; decode must hold id_instr.
- hit_rs1 / hit_rs2  out  1  valid tracked entry writes that register.
- sel_rs1 / sel_rs2  out  SIDX_W  stage index of the youngest matching entry (lowest index).
- load_use  out  1  a source matches an EX-stage load (LW, LWI, LM, LA) or a pending LM/LA register.
- wb_dest  out  RA_W  destination in WB.
- wb_valid  out  1  WB entry writes a register.

Behaviour:
- Decode rules, applied to id_instr on entry to EX:
  - ADD 0001 / NAND 0010: dest = [5:3].
  - ADI 0000: dest = [8:6].
  - LWI 0011, LW 0100, JAL 1001, JLR 1010: dest = [11:9].
  - LM 1100: mask = [NREG-1:0].
  - LA 1110: mask = all ones.
  - Any other opcode, or id_valid=0: valid = 0.
- Each entry holds {valid, dest, is_load, is_multi, mask}.
- Advance: on each rising clk with stall=0 and seq_busy=0, stage i moves to i+1, stage STAGES-1 retires, and stage 0 loads the decoded id_instr.
- LM/LA sequencing, when stage 0 holds is_multi:
  - seq_busy=1 while the mask has more than one set bit, or while the sequencer is not yet started.
  - Each unstalled cycle:
    - k = lowest set bit of the remaining mask;
    - push {valid=1, dest=k, is_load=1} into stage 1;
    - clear bit k;
    - stages >=1 shift normally.
  - When the last set bit is pushed, seq_busy drops combinationally in that cycle and stage 0 loads id_instr at the same edge.
  - Mask 0: one cycle, pushes valid=0 into stage 1, with no seq_busy extension.
  - LA pushes registers 0..NREG-1 in order, NREG cycles in total.
- Query logic, combinational from current state:
  - hit_rsX = any stage with valid and dest==rsX, or stage 0 is_multi with mask[rsX]=1.
  - sel_rsX = lowest matching stage index; a pending-mask match reports 0.
  - sel_rsX = 0 when there is no hit.
  - load_use = (stage 0 valid and is_load and dest matches rs1 or rs2) or a pending-mask match.
- Priority: reset > flush > stall > advance.
  - flush: stage 0 becomes invalid, sequencer mask is cleared, seq_busy=0. Stages >=1 still advance unless stall=1.
  - flush during the final LM push: the push is discarded.
  - stall=1 holds all state and the mask; queries still reflect held state.
- Reset, one cycle:
  - all entries have valid=0, dest=0, mask=0;
  - seq_busy=0, hit=0, sel=0, load_use=0, wb_dest=0, wb_valid=0.
  - Reset asserted mid-sequence aborts the sequence.
- Latency: an instruction decoded at edge n appears in WB (wb_valid) after edge n+STAGES-1, absent stalls.

Decomposition:
- Package dest_scoreboard_pkg: 4-bit opcode constants (OP_ADI, OP_ADD, OP_NAND, OP_LWI, OP_LW, OP_JAL, OP_JLR, OP_LM, OP_LA) and the entry record typedef.
- One sub-module: dest_decode, the combinational id_instr -> {valid, dest, is_load, is_multi, mask} decoder. It is reused by any stage needing local decode.

Test Plan:
- ADD 0001_101_110_001_001 then 3 bubbles:
  - wb_dest=001 and wb_valid=1 at the 3rd edge;
  - after the 1st edge, query rs1=001 gives hit_rs1=1, sel_rs1=0, load_use=0.
- LW 0100_101_110_001001, then query rs2=101 next cycle -> load_use=1, sel_rs2=0. One edge later -> load_use=0, sel_rs2=1.
- LM with mask 8'b0010_0101:
  - seq_busy=1 for exactly 2 cycles;
  - MEM dest sequence 0,2,5;
  - decode instruction accepted on the 3rd cycle;
  - query rs1=5 during the first cycle -> load_use=1.
- LA 1110_xxx: NREG pushes of dests 0..7 in order; LM with mask 0: no seq_busy, single invalid push.
- ADD to R3 in MEM and ADI to R3 in EX -> sel=0 (youngest wins). Assert stall 2 cycles -> all outputs frozen, no retirement.
- flush during an LM after its 1st push -> seq_busy=0 next cycle, the remaining registers are never pushed; reset mid-LA -> all outputs 0 after one edge.
